// File: rtl/board_dump_uart_if.sv
`default_nettype none
// ============================================================================
// Module      : board_dump_uart_if
// Description : Debug read port between the board dumper and the game board.
// Revision    : 1.0 - initial release
// ============================================================================

interface board_dump_uart_if;
    logic       e_debug;
    logic       read_board;
    logic [2:0] d_r_row;
    logic [2:0] d_r_col;
    logic [1:0] d_piece_data;

    modport master (
        output e_debug,
        output read_board,
        output d_r_row,
        output d_r_col,
        input  d_piece_data
    );

    modport slave (
        input  e_debug,
        input  read_board,
        input  d_r_row,
        input  d_r_col,
        output d_piece_data
    );
endinterface

`default_nettype wire

// File: rtl/board_dump_uart.sv
`default_nettype none
// ============================================================================
// Module      : board_dump_uart
// Description : Walks every board cell through the debug read port and sends
//               the board as ASCII lines (top row first) over an 8N1 UART.
// Revision    : 1.0 - initial release
// ============================================================================

module board_dump_uart #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int CLKS_PER_BIT = 217,
    parameter int READ_WAIT    = 1
) (
    input  wire               clk_25MHz,
    input  wire               rst_n,
    input  wire               dump_req,
    board_dump_uart_if.master board,
    output logic              uart_tx,
    output logic              busy,
    output logic              done
);

    localparam int c_CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_WAIT_W = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;

    localparam logic [c_CNT_W-1:0]  c_CLK_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(READ_WAIT);
    localparam logic [2:0]          c_ROW_TOP   = 3'(ROWS - 1);
    localparam logic [2:0]          c_COL_LAST  = 3'(COLS - 1);
    localparam logic [2:0]          c_BIT_LAST  = 3'd7;
    localparam logic [7:0]          c_CR        = 8'h0D;
    localparam logic [7:0]          c_LF        = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // What the byte currently on the wire is, so STOP knows what comes next.
    typedef enum logic [1:0] {
        K_CELL = 2'd0,
        K_CR   = 2'd1,
        K_LF   = 2'd2
    } kind_t;

    state_t              r_state,    w_state_nxt;
    kind_t               r_kind,     w_kind_nxt;
    logic [c_CNT_W-1:0]  r_clk_cnt,  w_clk_cnt_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic [2:0]          r_bit_idx,  w_bit_idx_nxt;
    logic [2:0]          r_row,      w_row_nxt;
    logic [2:0]          r_col,      w_col_nxt;
    logic [7:0]          r_tx_byte,  w_tx_byte_nxt;
    logic                r_done,     w_done_nxt;
    logic                w_bit_end;
    logic                w_fetch_end;
    logic                w_tx;

    function automatic logic [7:0] f_glyph(input logic [1:0] piece);
        logic [7:0] ch;
        case (piece)
            2'b00:   ch = 8'h2E;
            2'b01:   ch = 8'h31;
            2'b10:   ch = 8'h32;
            default: ch = 8'h3F;
        endcase
        return ch;
    endfunction

    assign w_bit_end   = (r_clk_cnt == c_CLK_LAST);
    assign w_fetch_end = (r_wait_cnt == c_WAIT_LAST);

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_kind     <= K_CELL;
            r_clk_cnt  <= '0;
            r_wait_cnt <= '0;
            r_bit_idx  <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_tx_byte  <= 8'hFF;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_kind     <= w_kind_nxt;
            r_clk_cnt  <= w_clk_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_kind_nxt     = r_kind;
        w_clk_cnt_nxt  = r_clk_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_tx_byte_nxt  = r_tx_byte;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (dump_req) begin
                    w_state_nxt    = S_FETCH;
                    w_kind_nxt     = K_CELL;
                    w_row_nxt      = c_ROW_TOP;
                    w_col_nxt      = 3'd0;
                    w_wait_cnt_nxt = '0;
                end
            end

            S_FETCH: begin
                // The board read is registered, so the address is held for
                // READ_WAIT extra cycles before the piece is captured.
                if (w_fetch_end) begin
                    w_tx_byte_nxt  = f_glyph(board.d_piece_data);
                    w_wait_cnt_nxt = '0;
                    w_clk_cnt_nxt  = '0;
                    w_state_nxt    = S_START;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = S_DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == c_BIT_LAST) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    case (r_kind)
                        K_CELL: begin
                            if (r_col == c_COL_LAST) begin
                                w_tx_byte_nxt = c_CR;
                                w_kind_nxt    = K_CR;
                                w_state_nxt   = S_START;
                            end else begin
                                w_col_nxt      = r_col + 3'd1;
                                w_wait_cnt_nxt = '0;
                                w_state_nxt    = S_FETCH;
                            end
                        end
                        K_CR: begin
                            w_tx_byte_nxt = c_LF;
                            w_kind_nxt    = K_LF;
                            w_state_nxt   = S_START;
                        end
                        default: begin
                            if (r_row == 3'd0) begin
                                w_done_nxt  = 1'b1;
                                w_kind_nxt  = K_CELL;
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_row_nxt      = r_row - 3'd1;
                                w_col_nxt      = 3'd0;
                                w_kind_nxt     = K_CELL;
                                w_wait_cnt_nxt = '0;
                                w_state_nxt    = S_FETCH;
                            end
                        end
                    endcase
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line level is decoded straight from registered state so that an
    // asynchronous reset returns the pin to idle-high at once.
    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = r_tx_byte[r_bit_idx];
            default: w_tx = 1'b1;
        endcase
    end

    assign uart_tx          = w_tx;
    assign busy             = (r_state != S_IDLE);
    assign done             = r_done;
    assign board.e_debug    = (r_state == S_FETCH);
    assign board.read_board = (r_state == S_FETCH);
    assign board.d_r_row    = r_row;
    assign board.d_r_col    = r_col;

endmodule

`default_nettype wire

// File: tb/tb_board_dump_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_dump_uart
// Description : Random-board bench for board_dump_uart with a UART decoder.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_board_dump_uart;

    localparam int ROWS      = 8;
    localparam int COLS      = 8;
    localparam int CPB       = 4;
    localparam int RW        = 1;
    localparam int FRAME_B   = ROWS * (COLS + 2);
    localparam int TOTAL_CYC = ROWS * COLS * (RW + 1) + FRAME_B * 10 * CPB;

    logic clk;
    logic rst_n;
    logic dump_req;
    logic uart_tx;
    logic busy;
    logic done;

    board_dump_uart_if bus ();

    board_dump_uart #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .CLKS_PER_BIT (CPB),
        .READ_WAIT    (RW)
    ) dut (
        .clk_25MHz (clk),
        .rst_n     (rst_n),
        .dump_req  (dump_req),
        .board     (bus),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Board with a one-cycle registered read.
    logic [1:0] board_mem [ROWS][COLS];
    logic [1:0] rd_q;
    always @(posedge clk) begin
        if (bus.e_debug && bus.read_board) rd_q <= board_mem[bus.d_r_row][bus.d_r_col];
    end
    assign bus.d_piece_data = rd_q;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input logic [1:0] p);
        case (p)
            2'd0:    return 8'h2E;
            2'd1:    return 8'h31;
            2'd2:    return 8'h32;
            default: return 8'h3F;
        endcase
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: fetch order, fetch window length, done pulses.
    int         fetch_idx        = 0;
    int         run_len          = 0;
    int         first_fetch_spec = -1;
    int         done_spec        = -1;
    int         fetch_gap        = -1;
    int         done_cnt         = 0;
    int         strobe_bad       = 0;
    int         tx_low_cnt       = 0;
    logic       prev_fetch       = 1'b0;
    logic [5:0] run_addr;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            fetch_idx  = 0;
            prev_fetch = 1'b0;
        end else begin
            if (bus.read_board !== bus.e_debug) strobe_bad++;
            if (uart_tx === 1'b0) tx_low_cnt++;
            if (bus.e_debug) begin
                if (!prev_fetch) begin
                    run_len  = 1;
                    run_addr = {bus.d_r_row, bus.d_r_col};
                    if (fetch_idx == 0) begin
                        first_fetch_spec = cyc + 1;
                        fetch_gap        = first_fetch_spec - done_spec;
                    end
                    check("fetch_row", 32'(bus.d_r_row), 32'(ROWS - 1 - fetch_idx / COLS));
                    check("fetch_col", 32'(bus.d_r_col), 32'(fetch_idx % COLS));
                    fetch_idx++;
                end else begin
                    run_len++;
                    check("fetch_hold", 32'({bus.d_r_row, bus.d_r_col}), 32'(run_addr));
                end
            end else if (prev_fetch) begin
                check("fetch_len", 32'(run_len), 32'(RW + 1));
            end
            prev_fetch = bus.e_debug;
            if (done) begin
                done_cnt++;
                done_spec = cyc + 1;
                fetch_idx = 0;
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // UART decoder: one byte = 10 slots of CPB cycles, every cycle recorded.
    logic [7:0] rx_q [$];
    logic       rx_samp [0:10*CPB-1];
    int         rx_n      = 0;
    bit         rx_active = 1'b0;

    initial forever begin
        int         glitch;
        logic [7:0] b;
        @(negedge clk);
        if (!rst_n) begin
            rx_active = 1'b0;
        end else begin
            if (!rx_active && uart_tx === 1'b0) begin
                rx_active = 1'b1;
                rx_n      = 0;
            end
            if (rx_active) begin
                rx_samp[rx_n] = uart_tx;
                rx_n++;
                if (rx_n == 10 * CPB) begin
                    rx_active = 1'b0;
                    glitch    = 0;
                    for (int k = 0; k < 10; k++)
                        for (int j = 1; j < CPB; j++)
                            if (rx_samp[k*CPB+j] !== rx_samp[k*CPB]) glitch++;
                    for (int k = 0; k < 8; k++) b[k] = rx_samp[(k+1)*CPB];
                    check("rx_stop", 32'(rx_samp[9*CPB]), 32'd1);
                    check("rx_bit_stable", 32'(glitch), 32'd0);
                    rx_q.push_back(b);
                end
            end
        end
    end

    task automatic randomize_board();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                board_mem[r][c] = 2'($urandom_range(0, 3));
    endtask

    task automatic clear_board();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                board_mem[r][c] = 2'd0;
    endtask

    // Returns at the falling edge inside the first cycle after the request edge.
    task automatic run_dump(input int pulse_at, output int t_req);
        rx_q.delete();
        @(negedge clk);
        dump_req = 1'b1;
        @(posedge clk);
        #1 t_req = cyc;
        @(negedge clk);
        dump_req = 1'b0;
        if (pulse_at > 0) begin
            repeat (pulse_at) @(negedge clk);
            dump_req = 1'b1;
            @(negedge clk);
            dump_req = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < TOTAL_CYC + 2000; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic compare_frame(input string tag);
        logic [7:0] exp_q [$];
        for (int r = ROWS - 1; r >= 0; r--) begin
            for (int c = 0; c < COLS; c++) exp_q.push_back(glyph(board_mem[r][c]));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
        check({tag, "_len"}, 32'(rx_q.size()), 32'(FRAME_B));
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_byte"}, (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    endtask

    task automatic finish_frame(input string tag, input int t_req);
        int d0;
        d0 = done_cnt;
        wait_done(tag);
        compare_frame(tag);
        check({tag, "_fetch_lat"}, 32'(first_fetch_spec - t_req), 32'd1);
        check({tag, "_cycles"}, 32'(done_spec - first_fetch_spec), 32'(TOTAL_CYC));
        repeat (4) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_strobes"}, 32'(strobe_bad), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int         t_req;
        int         low0;
        logic       s0;
        logic [3:0] slot;
        logic [9:0] lv;
        string      line1;
        string      line8;

        rst_n    = 1'b0;
        dump_req = 1'b1;
        clear_board();

        // Reset held with a pending request.
        repeat (4) @(negedge clk);
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_edbg", 32'(bus.e_debug), 32'd0);
        check("rst_rd", 32'(bus.read_board), 32'd0);
        check("rst_row", 32'(bus.d_r_row), 32'd0);
        check("rst_col", 32'(bus.d_r_col), 32'd0);
        rst_n    = 1'b1;
        dump_req = 1'b0;
        low0     = tx_low_cnt;
        repeat (200) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_tx_low", 32'(tx_low_cnt - low0), 32'd0);
        check("idle_done", 32'(done_cnt), 32'd0);
        check("idle_fetch", 32'(first_fetch_spec), 32'hFFFF_FFFF);

        // Empty board plus bit-level timing of the first byte '.'.
        clear_board();
        run_dump(0, t_req);
        s0 = uart_tx;
        @(negedge clk);
        check("fetch_tx_high", 32'({s0, uart_tx}), 32'b11);
        lv = {1'b1, 8'h2E, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                slot[j] = uart_tx;
            end
            check($sformatf("bit_slot%0d", k), 32'(slot), 32'({4{lv[k]}}));
        end
        finish_frame("empty", t_req);

        // Fixed contents.
        clear_board();
        board_mem[0][3] = 2'd1;
        board_mem[0][4] = 2'd2;
        board_mem[7][7] = 2'd3;
        run_dump(0, t_req);
        wait_done("contents");
        line1 = ".......?";
        line8 = "...12...";
        for (int i = 0; i < 8; i++) begin
            check("line1", 32'(rx_q[i]), 32'(line1[i]));
            check("line8", 32'(rx_q[70+i]), 32'(line8[i]));
        end
        check("line_end", 32'({rx_q[78], rx_q[79]}), 32'h0D0A);
        compare_frame("contents");

        // Random boards, the second with a request pulse mid-dump.
        randomize_board();
        run_dump(0, t_req);
        finish_frame("rand1", t_req);
        randomize_board();
        run_dump($urandom_range(50, 3000), t_req);
        finish_frame("rand_pulse", t_req);

        // Request held high through done: back-to-back frames.
        randomize_board();
        rx_q.delete();
        @(negedge clk);
        dump_req = 1'b1;
        wait_done("held1");
        compare_frame("held1");
        rx_q.delete();
        repeat (10) @(negedge clk);
        check("held_gap", 32'(fetch_gap), 32'd1);
        dump_req = 1'b0;
        wait_done("held2");
        compare_frame("held2");
        check("held2_cycles", 32'(done_spec - first_fetch_spec), 32'(TOTAL_CYC));
        repeat (4) @(negedge clk);
        check("held2_idle", 32'(busy), 32'd0);

        // Reset during data bit 3 of the first byte '1'.
        randomize_board();
        board_mem[ROWS-1][0] = 2'd1;
        run_dump(0, t_req);
        repeat (19) @(negedge clk);
        check("pre_reset_tx", 32'(uart_tx), 32'd0);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(uart_tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_row", 32'(bus.d_r_row), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        low0  = tx_low_cnt;
        repeat (60) @(negedge clk);
        check("post_rst_rx", 32'(rx_q.size()), 32'd0);
        check("post_rst_quiet", 32'(tx_low_cnt - low0), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        run_dump(0, t_req);
        finish_frame("after_rst", t_req);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
